// File: rtl/div_unit_pkg.sv
// Shared RV32 types and constants for the M-extension divide path.
package div_unit_pkg;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [2:0] {
    DIV  = 3'b100,
    DIVU = 3'b101,
    REM  = 3'b110,
    REMU = 3'b111
  } m_div_funct3_t;

  localparam rv32i_word DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam rv32i_word INT_MIN       = 32'h8000_0000;

  function automatic logic is_signed_op(input m_div_funct3_t f);
    return ~f[0];
  endfunction

  function automatic logic is_rem_op(input m_div_funct3_t f);
    return f[1];
  endfunction

endpackage

// File: rtl/divider.sv
// Unsigned restoring divider: one quotient bit per cycle, div_valid pulses
// 33 cycles after the start cycle. Divisor must be held stable while busy.
module divider
  import div_unit_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      start,
  input  rv32i_word a,
  input  rv32i_word b,
  output logic      div_valid,
  output rv32i_word quotient,
  output rv32i_word remain
);

  logic [5:0]  cnt;
  logic        busy;
  logic [32:0] trial;
  logic [32:0] diff;

  always_comb begin
    trial = {remain, quotient[31]};
    diff  = trial - {1'b0, b};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      busy      <= 1'b0;
      div_valid <= 1'b0;
      quotient  <= '0;
      remain    <= '0;
    end else begin
      div_valid <= 1'b0;
      if (start) begin
        remain   <= '0;
        quotient <= a;
        cnt      <= 6'd32;
        busy     <= 1'b1;
      end else if (busy) begin
        // diff[32] is the borrow: set when the partial remainder is below b
        if (!diff[32]) begin
          remain   <= diff[31:0];
          quotient <= {quotient[30:0], 1'b1};
        end else begin
          remain   <= trial[31:0];
          quotient <= {quotient[30:0], 1'b0};
        end
        cnt <= cnt - 6'd1;
        if (cnt == 6'd1) begin
          busy      <= 1'b0;
          div_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/div_unit.sv
// RV32M divide front end: resolves divide-by-zero/overflow directly, otherwise
// runs magnitudes through the unsigned divider and sign-corrects the result.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int TAG_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_funct3,
  input  rv32i_word            req_rs1,
  input  rv32i_word            req_rs2,
  input  logic [TAG_WIDTH-1:0] req_tag,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output rv32i_word            resp_data,
  output logic [TAG_WIDTH-1:0] resp_tag
);

  typedef enum logic [2:0] {IDLE, START, WAIT, DONE, DRAIN} state_t;

  state_t        state;
  m_div_funct3_t funct3_q;
  rv32i_word     a_mag, b_mag;
  logic          neg_q, neg_r;

  logic          div_start, div_valid;
  rv32i_word     quotient, remain;

  m_div_funct3_t f3_in;
  logic          sgn_in, neg_a_in, neg_b_in, special_in;
  rv32i_word     special_data, div_result;

  always_comb begin
    // bit 2 is the M-extension marker and carries no operation information
    f3_in      = m_div_funct3_t'({req_funct3[2] | 1'b1, req_funct3[1:0]});
    sgn_in     = is_signed_op(f3_in);
    neg_a_in   = sgn_in & req_rs1[31];
    neg_b_in   = sgn_in & req_rs2[31];
    special_in = 1'b0;
    special_data = '0;
    if (req_rs2 == '0) begin
      special_in   = 1'b1;
      special_data = is_rem_op(f3_in) ? req_rs1 : DIV_BY_ZERO_Q;
    end else if (sgn_in && req_rs1 == INT_MIN && req_rs2 == DIV_BY_ZERO_Q) begin
      special_in   = 1'b1;
      special_data = is_rem_op(f3_in) ? '0 : INT_MIN;
    end
    if (is_rem_op(funct3_q)) div_result = neg_r ? (32'd0 - remain) : remain;
    else                     div_result = neg_q ? (32'd0 - quotient) : quotient;
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE);
  assign div_start  = (state == START);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      funct3_q  <= DIVU;
      a_mag     <= '0;
      b_mag     <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      resp_data <= '0;
      resp_tag  <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid && !flush) begin
          funct3_q <= f3_in;
          a_mag    <= neg_a_in ? (32'd0 - req_rs1) : req_rs1;
          b_mag    <= neg_b_in ? (32'd0 - req_rs2) : req_rs2;
          neg_q    <= neg_a_in ^ neg_b_in;
          neg_r    <= neg_a_in;
          resp_tag <= req_tag;
          if (special_in) begin
            resp_data <= special_data;
            state     <= DONE;
          end else begin
            state <= START;
          end
        end
        START: state <= flush ? DRAIN : WAIT;
        WAIT: begin
          if (flush) begin
            state <= div_valid ? IDLE : DRAIN;
          end else if (div_valid) begin
            resp_data <= div_result;
            state     <= DONE;
          end
        end
        DONE:  if (flush || resp_ready) state <= IDLE;
        DRAIN: if (div_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  divider u_divider (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .a        (a_mag),
    .b        (b_mag),
    .div_valid(div_valid),
    .quotient (quotient),
    .remain   (remain)
  );

endmodule

// File: tb/tb_div_unit.sv
// Directed + scoreboard bench for div_unit; expected results come from
// literal vectors or an independent signed/unsigned division model.
module tb_div_unit;

  localparam int TW = 5;
  localparam int L  = 33;
  localparam int NORM_LAT = 2 + L;

  logic          clk = 1'b0;
  logic          rst, flush, req_valid, req_ready;
  logic [2:0]    req_funct3;
  logic [31:0]   req_rs1, req_rs2;
  logic [TW-1:0] req_tag;
  logic          resp_valid, resp_ready;
  logic [31:0]   resp_data;
  logic [TW-1:0] resp_tag;

  div_unit #(.TAG_WIDTH(TW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_tag(resp_tag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int starts = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dut.div_start) starts <= starts + 1;
  end

  typedef struct packed {
    logic [31:0]   data;
    logic [TW-1:0] tag;
  } exp_t;
  exp_t sb[$];

  int n_assert = 0;
  int n_fail   = 0;
  int t_acc, s_acc, stray;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic sg, rm;
    sg = ~f3[0];
    rm = f3[1];
    if (b == 32'd0) return rm ? a : 32'hFFFF_FFFF;
    if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rm ? 32'd0 : 32'h8000_0000;
    if (sg) return rm ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
    return rm ? a % b : a / b;
  endfunction

  // Present a request at a negedge and hold it until accepted (bounded).
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [TW-1:0] tag, input logic [31:0] exp, input bit push);
    int n;
    n = 0;
    stray = 0;
    req_valid  = 1'b1;
    req_funct3 = f3;
    req_rs1    = a;
    req_rs2    = b;
    req_tag    = tag;
    while (!req_ready && n < 200) begin
      if (resp_valid) stray++;
      @(negedge clk);
      n++;
    end
    t_acc = cyc;
    s_acc = starts;
    if (push) sb.push_back('{data: exp, tag: tag});
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic collect(input int exp_lat, input int exp_starts, input int hold);
    exp_t e;
    while (!resp_valid && (cyc - t_acc) < 200) @(negedge clk);
    chk("latency", cyc - t_acc, exp_lat);
    chk("start_pulses", starts - s_acc, exp_starts);
    n_assert++;
    assert (sb.size() > 0) else begin
      n_fail++;
      $error("FAIL sb_underflow: observed response with tag %h, expected none", resp_tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("resp_data", resp_data, e.data);
      chk("resp_tag", resp_tag, e.tag);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_data", resp_data, e.data);
        chk("hold_tag", resp_tag, e.tag);
        chk("hold_req_ready", req_ready, 0);
        chk("hold_resp_valid", resp_valid, 1);
      end
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("ready_after_resp", req_ready, 1);
    chk("valid_after_resp", resp_valid, 0);
  endtask

  task automatic op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                    input logic [TW-1:0] tag, input logic [31:0] exp,
                    input int lat, input int st, input int hold);
    issue(f3, a, b, tag, exp, 1'b1);
    collect(lat, st, hold);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    bit          sp;
    int          t1;

    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_funct3 = '0; req_rs1 = '0; req_rs2 = '0; req_tag = '0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_tag", resp_tag, 0);
    chk("rst_start", dut.div_start, 0);
    rst = 1'b0;
    @(negedge clk);

    op(3'b101, 32'd40, 32'd20, 5'd3, 32'd2, NORM_LAT, 1, 0);
    op(3'b111, 32'd40, 32'd20, 5'd4, 32'd0, NORM_LAT, 1, 0);
    op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, NORM_LAT, 1, 0);
    op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, NORM_LAT, 1, 0);
    op(3'b100, 32'd7, 32'hFFFF_FFFE, 5'd7, 32'hFFFF_FFFD, NORM_LAT, 1, 0);
    op(3'b110, 32'd7, 32'hFFFF_FFFE, 5'd8, 32'd1, NORM_LAT, 1, 0);
    op(3'b001, 32'd40, 32'd20, 5'd20, 32'd2, NORM_LAT, 1, 0);

    op(3'b101, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF, 1, 0, 0);
    op(3'b111, 32'd5, 32'd0, 5'd10, 32'd5, 1, 0, 0);
    op(3'b100, 32'hFFFF_FFFB, 32'd0, 5'd11, 32'hFFFF_FFFF, 1, 0, 0);
    op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1, 0, 0);
    op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0, 1, 0, 0);

    op(3'b101, 32'd100, 32'd7, 5'd14, 32'd14, NORM_LAT, 1, 4);

    for (int i = 0; i < 6; i++) begin
      f3 = 3'(4 + $urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 20);
        2:       b = 32'd0 - 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      if (i == 5) begin a = 32'h8000_0000; b = 32'd3; f3 = 3'b110; end
      sp = (b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
      op(f3, a, b, TW'(i + 21), model(f3, a, b), sp ? 1 : NORM_LAT, sp ? 0 : 1, 0);
    end

    // flush in the accept cycle drops the request
    req_valid = 1'b1; flush = 1'b1; req_funct3 = 3'b101; req_rs1 = 32'd9; req_rs2 = 32'd3;
    s_acc = starts;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    chk("accflush_ready", req_ready, 1);
    chk("accflush_valid", resp_valid, 0);
    repeat (3) @(negedge clk);
    chk("accflush_starts", starts - s_acc, 0);

    // flush in DONE returns to IDLE without a handshake
    issue(3'b101, 32'd5, 32'd0, 5'd15, 32'd0, 1'b0);
    chk("doneflush_valid_pre", resp_valid, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("doneflush_valid", resp_valid, 0);
    chk("doneflush_ready", req_ready, 1);

    // flush mid-WAIT: next request blocked until the stale div_valid drains
    issue(3'b101, 32'd100, 32'd3, 5'd1, 32'd0, 1'b0);
    t1 = t_acc;
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    issue(3'b101, 32'd9, 32'd3, 5'd2, 32'd3, 1'b1);
    chk("drain_release", t_acc - t1, L + 2);
    chk("drain_no_stray", stray, 0);
    collect(NORM_LAT, 1, 0);

    // reset mid-WAIT: outputs back to reset values, divider restarts clean
    issue(3'b101, 32'd1000, 32'd10, 5'd7, 32'd0, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_resp_valid", resp_valid, 0);
    chk("midrst_resp_data", resp_data, 0);
    chk("midrst_resp_tag", resp_tag, 0);
    chk("midrst_start", dut.div_start, 0);
    op(3'b101, 32'd40, 32'd20, 5'd3, 32'd2, NORM_LAT, 1, 0);
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

RV32M divide front end that sits directly upstream of the unsigned iterative `divider`. It accepts DIV/DIVU/REM/REMU requests over a valid/ready handshake and resolves the RISC-V special cases (divide-by-zero, signed overflow) without engaging the core. It converts signed operands to magnitudes, sequences the `divider` start/valid handshake, sign-corrects the result, and holds it until the consumer accepts.

## Interface
- `TAG_WIDTH`, 5: width of the opaque tag (rd / ROB index) carried from request to response.
- `clk`  in  1  clock; all logic on posedge.
- `rst`  in  1  reset; synchronous, active-high; also drives `divider` reset.
- `flush`  in  1  abort any in-flight request.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept.
- `req_funct3`  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU; bit 2 ignored.
- `req_rs1`  in  32  dividend (`rv32i_word`).
- `req_rs2`  in  32  divisor (`rv32i_word`).
- `req_tag`  in  TAG_WIDTH  returned unchanged.
- `resp_valid`  out  1  result present.
- `resp_ready`  in  1  consumer accepts.
- `resp_data`  out  32  quotient or remainder.
- `resp_tag`  out  TAG_WIDTH  tag of the request.

## Operation
- States: IDLE, START, WAIT, DONE, DRAIN. Reset → IDLE.
- Reset values: `req_ready`=1, `resp_valid`=0, `resp_data`=0, `resp_tag`=0, divider `start`=0.
- `req_ready` = (state==IDLE). Accept on `req_valid && req_ready`. Register funct3, tag, and sign flags. Register magnitude operands: |x| = two's-complement negate when signed op and x[31]=1, so 0x80000000 stays 0x80000000.
- Special cases are decided at accept from raw operands. The result is registered and the state goes IDLE→DONE.
  - rs2==0: quotient 0xFFFFFFFF (signed and unsigned), remainder rs1.
  - Signed and rs1==0x80000000 and rs2==0xFFFFFFFF: quotient 0x80000000, remainder 0.
- Otherwise IDLE→START. START drives `divider.start`=1 for exactly one cycle with registered magnitudes on `a`/`b`, then START→WAIT. Operands stay stable until `div_valid`.
- WAIT: on `div_valid`, select quotient or remain per funct3[1] and sign-correct.
  - Negate quotient iff signed and rs1[31]≠rs2[31].
  - Negate remainder iff signed and rs1[31]=1.
  - Register the result, then WAIT→DONE.
- DONE: `resp_valid`=1. Data and tag stay stable while `resp_ready`=0. On `resp_ready`, DONE→IDLE.
- `flush` has priority over all transitions:
  - From IDLE or DONE → IDLE, with `resp_valid` deasserted the next cycle.
  - From START or WAIT → DRAIN. DRAIN holds `req_ready`=0 until `div_valid`, discards the result, and goes to IDLE. A flush in START still counts as a started division.
  - A flush in the accept cycle drops the request.
- `rst` mid-operation: everything returns to reset values next cycle. The divider is reset too; no drain.

## Timing
- Accept at cycle T.
- Special case: `resp_valid` at T+1.
- Normal case: `start` high at T+1. With `div_valid` at T+1+L, `resp_valid` is at T+2+L.
- Back-to-back: the earliest next accept is the cycle after the `resp_valid && resp_ready` handshake (no same-cycle bypass).
- `flush` and `div_valid` in the same WAIT cycle: the result is discarded and the state goes to IDLE directly.
- `flush` and `resp_ready` in DONE: the response counts as consumed.
- No combinational path from `resp_ready` or `req_valid` to `req_ready`.

## Structure
- `rv32i_types` gains a `m_div_funct3_t` enum (DIV, DIVU, REM, REMU) and constants `DIV_BY_ZERO_Q` = 32'hFFFFFFFF and `INT_MIN` = 32'h80000000. It reuses `rv32i_word`.
- The FSM state enum is local to `div_unit`.
- One sub-module: the existing `divider` (ports `clk`, `rst`, `start`, `a`, `b`, `div_valid`, `quotient`, `remain`), instantiated once.

## Test plan
- DIVU 40/20 tag 3 → `resp_data`=2, `resp_tag`=3. REMU 40/20 → 0. Normal-case latency is 2+L.
- DIV 0xFFFFFFF9(−7)/2 → 0xFFFFFFFD. REM → 0xFFFFFFFF. DIV 7/0xFFFFFFFE → 0xFFFFFFFD. REM 7/−2 → 1.
- DIVU 5/0 → 0xFFFFFFFF. REMU 5/0 → 5. DIV −5/0 → 0xFFFFFFFF. Each has `resp_valid` at T+1 and `divider.start` never pulses.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM → 0. Both at T+1.
- Hold `resp_ready`=0 for 4 cycles in DONE → `resp_data`/`resp_tag` stable and `req_ready`=0. The release cycle consumes the response; `req_ready`=1 the next cycle.
- `flush` mid-WAIT, then a DIVU 9/3 request → `req_ready` stays 0 until the stale `div_valid`. The new response is 3 with the new tag, and no stale response appears. Assert `rst` mid-WAIT → all outputs at reset values next cycle.
